// File: rtl/stream_rr_arbiter.sv
// Two-input AXI-stream round-robin merger with a burst limit per grant and a
// single output register stage; counts accepted beats per input.
module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [WIDTH-1:0] Input_1_V_TDATA,
    input  logic             Input_1_V_TVALID,
    output logic             Input_1_V_TREADY,
    input  logic [WIDTH-1:0] Input_2_V_TDATA,
    input  logic             Input_2_V_TVALID,
    output logic             Input_2_V_TREADY,
    output logic [WIDTH-1:0] Output_1_V_TDATA,
    output logic             Output_1_V_TVALID,
    input  logic             Output_1_V_TREADY,
    output logic             ap_idle,
    output logic [31:0]      beats_1,
    output logic [31:0]      beats_2,
    output logic [1:0]       dbg_state,
    output logic [7:0]       dbg_cnt
);

    // Handshake: a beat moves on a port only in a cycle where TVALID and TREADY
    // are both high at the rising edge; TREADY never depends on the same
    // port's TVALID, and the output holds TDATA/TVALID while stalled.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(BURST - 1);

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             last, last_nxt;   // 0: input 1 granted last, 1: input 2
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             slot_free;
    logic             xfer_1, xfer_2, out_xfer;

    assign slot_free         = !out_vld || Output_1_V_TREADY;
    assign Input_1_V_TREADY  = (state == GRANT1) && slot_free && !ap_rst;
    assign Input_2_V_TREADY  = (state == GRANT2) && slot_free && !ap_rst;
    assign xfer_1            = Input_1_V_TVALID && Input_1_V_TREADY;
    assign xfer_2            = Input_2_V_TVALID && Input_2_V_TREADY;
    assign out_xfer          = out_vld && Output_1_V_TREADY;
    assign Output_1_V_TVALID = out_vld;
    assign Output_1_V_TDATA  = out_data;
    assign ap_idle           = (state == IDLE) && !out_vld;
    assign dbg_state         = state;
    assign dbg_cnt           = cnt;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (Input_1_V_TVALID && Input_2_V_TVALID)
                    state_nxt = last ? GRANT1 : GRANT2;
                else if (Input_1_V_TVALID)
                    state_nxt = GRANT1;
                else if (Input_2_V_TVALID)
                    state_nxt = GRANT2;
            end
            GRANT1: begin
                if (!Input_1_V_TVALID) begin
                    state_nxt = Input_2_V_TVALID ? GRANT2 : IDLE;
                    cnt_nxt   = 8'd0;
                    last_nxt  = 1'b0;
                end else if (xfer_1) begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt = 8'd0;
                        if (Input_2_V_TVALID) begin
                            state_nxt = GRANT2;
                            last_nxt  = 1'b0;
                        end
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            GRANT2: begin
                if (!Input_2_V_TVALID) begin
                    state_nxt = Input_1_V_TVALID ? GRANT1 : IDLE;
                    cnt_nxt   = 8'd0;
                    last_nxt  = 1'b1;
                end else if (xfer_2) begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt = 8'd0;
                        if (Input_1_V_TVALID) begin
                            state_nxt = GRANT1;
                            last_nxt  = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // An input beat always refills the register, even when the old beat leaves
    // in the same cycle; only a lone output transfer empties it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (xfer_1 || xfer_2) begin
            out_vld  <= 1'b1;
            out_data <= xfer_1 ? Input_1_V_TDATA : Input_2_V_TDATA;
        end else if (out_xfer) begin
            out_vld  <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            beats_1 <= 32'd0;
            beats_2 <= 32'd0;
        end else begin
            if (xfer_1) beats_1 <= beats_1 + 32'd1;
            if (xfer_2) beats_2 <= beats_2 + 32'd1;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: cycle table for the steady round-robin pattern,
// hand sequences for stall/drop/reset/wrap, and a randomized scoreboard run.
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d1, d2, od;
    logic        v1, v2, r1, r2, ov, ordy, idle;
    logic [31:0] b1, b2;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // source bookkeeping: beats taken from each input, data = base + taken
    int unsigned k1, k2;
    logic [31:0] base1, base2;

    logic        sb_on;
    logic        prev_stall;
    logic [31:0] prev_od;
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    typedef struct {
        logic        v1, v2, ordy;
        logic        r1, r2, ov, idle;
        logic [31:0] od;
    } vec_t;

    vec_t vecs[15];

    stream_rr_arbiter #(.WIDTH(32), .BURST(4)) dut (
        .ap_clk           (clk),
        .ap_rst           (rst),
        .Input_1_V_TDATA  (d1),
        .Input_1_V_TVALID (v1),
        .Input_1_V_TREADY (r1),
        .Input_2_V_TDATA  (d2),
        .Input_2_V_TVALID (v2),
        .Input_2_V_TREADY (r2),
        .Output_1_V_TDATA (od),
        .Output_1_V_TVALID(ov),
        .Output_1_V_TREADY(ordy),
        .ap_idle          (idle),
        .beats_1          (b1),
        .beats_2          (b2),
        .dbg_state        (dbg_state),
        .dbg_cnt          (dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v1 = 1'b0;
        v2 = 1'b0;
        ordy = 1'b0;
        k1 = 0;
        k2 = 0;
        d1 = base1;
        d2 = base2;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic to_neg();
        @(negedge clk);
    endtask

    // called at the negedge: scoreboard, source bookkeeping, then advance
    task automatic end_cyc();
        if (ov && ordy) got_q.push_back(od);
        if (sb_on) begin
            check("ready_exclusive", {31'd0, r1 & r2}, 32'd0);
            if (prev_stall) begin
                check("hold_valid", {31'd0, ov}, 32'd1);
                check("hold_data", od, prev_od);
            end
            if (ov && ordy) begin
                if (od[31:28] == 4'h1) begin
                    if (exp_q1.size() == 0) check("sb_src1_extra", od, 32'hxxxx_xxxx);
                    else check("sb_src1_data", od, exp_q1.pop_front());
                end else if (od[31:28] == 4'h2) begin
                    if (exp_q2.size() == 0) check("sb_src2_extra", od, 32'hxxxx_xxxx);
                    else check("sb_src2_data", od, exp_q2.pop_front());
                end else begin
                    check("sb_tag", {28'd0, od[31:28]}, 32'd1);
                end
            end
            if (v1 && r1) exp_q1.push_back(d1);
            if (v2 && r2) exp_q2.push_back(d2);
            prev_stall = ov && !ordy;
            prev_od = od;
        end
        if (v1 && r1) k1++;
        if (v2 && r2) k2++;
        @(posedge clk);
        #1;
        d1 = base1 + k1;
        d2 = base2 + k2;
    endtask

    task automatic cyc();
        to_neg();
        end_cyc();
    endtask

    function automatic vec_t mk(input logic a1, input logic a2, input logic ar,
                                input logic e1, input logic e2, input logic eov,
                                input logic eidle, input logic [31:0] eod);
        vec_t v;
        v.v1 = a1; v.v2 = a2; v.ordy = ar;
        v.r1 = e1; v.r2 = e2; v.ov = eov; v.idle = eidle; v.od = eod;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        sb_on = 1'b0;
        base1 = 32'h100;
        base2 = 32'h200;

        // both inputs always valid, BURST=4: one arbitration cycle, then 4/4 alternation
        vecs[0]  = mk(1, 1, 1, 0, 0, 0, 1, 32'h0);
        vecs[1]  = mk(1, 1, 1, 1, 0, 0, 0, 32'h0);
        vecs[2]  = mk(1, 1, 1, 1, 0, 1, 0, 32'h100);
        vecs[3]  = mk(1, 1, 1, 1, 0, 1, 0, 32'h101);
        vecs[4]  = mk(1, 1, 1, 1, 0, 1, 0, 32'h102);
        vecs[5]  = mk(1, 1, 1, 0, 1, 1, 0, 32'h103);
        vecs[6]  = mk(1, 1, 1, 0, 1, 1, 0, 32'h200);
        vecs[7]  = mk(1, 1, 1, 0, 1, 1, 0, 32'h201);
        vecs[8]  = mk(1, 1, 1, 0, 1, 1, 0, 32'h202);
        vecs[9]  = mk(1, 1, 1, 1, 0, 1, 0, 32'h203);
        vecs[10] = mk(1, 1, 1, 1, 0, 1, 0, 32'h104);
        vecs[11] = mk(1, 1, 1, 1, 0, 1, 0, 32'h105);
        vecs[12] = mk(1, 1, 0, 0, 0, 1, 0, 32'h106);
        vecs[13] = mk(1, 1, 1, 1, 0, 1, 0, 32'h106);
        vecs[14] = mk(1, 1, 1, 0, 1, 1, 0, 32'h107);

        do_reset();
        to_neg();
        check("rst_valid", {31'd0, ov}, 32'd0);
        check("rst_ready", {30'd0, r1, r2}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_beats_1", b1, 32'd0);
        check("rst_beats_2", b2, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        end_cyc();

        do_reset();
        for (int i = 0; i < 15; i++) begin
            v1 = vecs[i].v1;
            v2 = vecs[i].v2;
            ordy = vecs[i].ordy;
            to_neg();
            check($sformatf("tbl%0d_ready_1", i), {31'd0, r1}, {31'd0, vecs[i].r1});
            check($sformatf("tbl%0d_ready_2", i), {31'd0, r2}, {31'd0, vecs[i].r2});
            check($sformatf("tbl%0d_valid", i), {31'd0, ov}, {31'd0, vecs[i].ov});
            check($sformatf("tbl%0d_idle", i), {31'd0, idle}, {31'd0, vecs[i].idle});
            if (vecs[i].ov) check($sformatf("tbl%0d_data", i), od, vecs[i].od);
            end_cyc();
        end

        // only input 2: ten beats in order after one arbitration cycle
        base2 = 32'h10;
        do_reset();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'h10 + i);
        v2 = 1'b1;
        ordy = 1'b1;
        to_neg();
        check("s2_arb_latency", {31'd0, r2}, 32'd0);
        end_cyc();
        for (int i = 0; i < 40 && got_q.size() < 10; i++) begin
            if (k2 == 10) v2 = 1'b0;
            cyc();
        end
        v2 = 1'b0;
        to_neg();
        check("s2_count", got_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check($sformatf("s2_beat%0d", i), got_q[i], exp_q[i]);
        check("s2_beats_2", b2, 32'd10);
        check("s2_beats_1", b1, 32'd0);
        check("s2_idle_after", {31'd0, idle}, 32'd1);
        end_cyc();

        // back-pressure in the middle of an input 1 burst
        base1 = 32'hA00;
        do_reset();
        v1 = 1'b1;
        ordy = 1'b1;
        repeat (3) cyc();
        ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            check("bp_valid", {31'd0, ov}, 32'd1);
            check("bp_data", od, 32'hA01);
            check("bp_ready_1", {31'd0, r1}, 32'd0);
            check("bp_cnt", {24'd0, dbg_cnt}, 32'd2);
            end_cyc();
        end
        ordy = 1'b1;
        to_neg();
        check("bp_release_ready", {31'd0, r1}, 32'd1);
        end_cyc();
        to_neg();
        check("bp_cnt_last", {24'd0, dbg_cnt}, 32'd3);
        end_cyc();
        v1 = 1'b0;
        to_neg();
        check("bp_total_beats", k1, 32'd4);
        check("bp_cnt_wrapped", {24'd0, dbg_cnt}, 32'd0);
        end_cyc();

        // input 1 drops valid after two beats: grant moves straight to input 2
        base1 = 32'h300;
        base2 = 32'h400;
        do_reset();
        v1 = 1'b1;
        v2 = 1'b1;
        ordy = 1'b1;
        repeat (3) cyc();
        v1 = 1'b0;
        to_neg();
        check("drop_beats_1", k1, 32'd2);
        check("drop_still_grant1", {31'd0, r1}, 32'd1);
        end_cyc();
        to_neg();
        check("drop_ready_2", {31'd0, r2}, 32'd1);
        check("drop_state", {30'd0, dbg_state}, 32'd2);
        end_cyc();
        v2 = 1'b0;
        repeat (3) cyc();

        // reset pulse while a beat from input 2 sits in the output register
        do_reset();
        v2 = 1'b1;
        ordy = 1'b1;
        repeat (2) cyc();
        v1 = 1'b1;
        rst = 1'b1;
        to_neg();
        check("rstp_valid_before", {31'd0, ov}, 32'd1);
        check("rstp_ready_during", {30'd0, r1, r2}, 32'd0);
        end_cyc();
        rst = 1'b0;
        to_neg();
        check("rstp_valid_after", {31'd0, ov}, 32'd0);
        check("rstp_beats_1", b1, 32'd0);
        check("rstp_beats_2", b2, 32'd0);
        check("rstp_ready_after", {30'd0, r1, r2}, 32'd0);
        end_cyc();
        to_neg();
        check("rstp_tie_to_1", {30'd0, r1, r2}, 32'd2);
        end_cyc();

        // beats_1 counter wrap
        do_reset();
        force dut.beats_1 = 32'hFFFF_FFFE;
        cyc();
        release dut.beats_1;
        to_neg();
        check("wrap_preload", b1, 32'hFFFF_FFFE);
        end_cyc();
        v1 = 1'b1;
        ordy = 1'b1;
        for (int i = 0; i < 20 && k1 < 3; i++) cyc();
        v1 = 1'b0;
        to_neg();
        check("wrap_taken", k1, 32'd3);
        check("wrap_value", b1, 32'h0000_0001);
        end_cyc();

        // randomized traffic against per-input order scoreboard
        base1 = 32'h1000_0000;
        base2 = 32'h2000_0000;
        do_reset();
        exp_q1.delete();
        exp_q2.delete();
        sb_on = 1'b1;
        for (int p = 0; p < 10; p++) begin
            int unsigned p1, p2, pr;
            p1 = $urandom_range(0, 4);
            p2 = $urandom_range(0, 4);
            pr = $urandom_range(0, 4);
            for (int c = 0; c < 200; c++) begin
                v1 = ($urandom_range(0, 4) < p1 + 1);
                v2 = ($urandom_range(0, 4) < p2 + 1);
                ordy = ($urandom_range(0, 4) < pr + 1);
                cyc();
            end
        end
        v1 = 1'b0;
        v2 = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 20 && (ov || !idle); i++) cyc();
        to_neg();
        check("rand_drained_1", exp_q1.size(), 32'd0);
        check("rand_drained_2", exp_q2.size(), 32'd0);
        check("rand_beats_1", b1, k1);
        check("rand_beats_2", b2, k2);
        check("rand_idle", {31'd0, idle}, 32'd1);
        end_cyc();
        sb_on = 1'b0;

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
